inhibit_edge_bank: RTL and testbench

- Parametrised, registered, multi-channel successor to the team's combinational "a and not b" inhibit function.
- Each channel samples its input, detects edges in a runtime-selected mode, and gates each edge with a per-channel inhibit (event = edge & ~inhibit).
- Each accepted event produces a one-cycle pulse, sets a sticky flag and increments a saturating event counter.
- Sits between raw level signals (switches, status lines) and control logic that needs clean single-cycle events and occurrence counts.

---
 rtl/inhibit_edge_bank_pkg.sv | 20 ++
 rtl/inhibit_edge_bank_edge_cell.sv | 60 ++++++
 rtl/inhibit_edge_bank.sv | 40 ++++
 tb/tb_inhibit_edge_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/inhibit_edge_bank_pkg.sv
// Shared edge-mode encoding and the edge-select helper used by every channel.
package inhibit_edge_bank_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    function automatic logic sel_edge(input mode_e m, input logic rise, input logic fall);
        unique case (m)
            MODE_RISE: sel_edge = rise;
            MODE_FALL: sel_edge = fall;
            MODE_BOTH: sel_edge = rise | fall;
            default:   sel_edge = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/inhibit_edge_bank_edge_cell.sv
// One channel: two-stage sampler, mode-selected edge, inhibit gate, pulse,
// sticky flag and saturating event counter.
module edge_cell
    import inhibit_edge_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_din,
    input  logic             i_inhibit,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_pulse,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_count
);

    logic             r_s1;
    logic             r_s2;
    logic             r_pulse;
    logic             r_flag;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;
    logic             w_fall;
    logic             w_event;

    assign w_rise  = r_s1 & ~r_s2;
    assign w_fall  = ~r_s1 & r_s2;
    assign w_event = sel_edge(mode_e'(i_mode), w_rise, w_fall) & ~i_inhibit;

    // clr only touches flag/count; the sampler and pulse keep running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_din;
            r_s2    <= r_s1;
            r_pulse <= w_event;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_flag  <= 1'b0;
            r_count <= '0;
        end else if (r_pulse) begin
            r_flag <= 1'b1;
            if (r_count != {CNT_W{1'b1}})
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;
    assign o_count = r_count;

endmodule

// File: rtl/inhibit_edge_bank.sv
// Bank of WIDTH independent edge_cell channels sharing mode and clr; packs
// the per-channel counters and ORs the pulses.
module inhibit_edge_bank
    import inhibit_edge_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic [WIDTH-1:0]       inhibit,
    input  logic [1:0]             mode,
    input  logic                   clr,
    output logic [WIDTH-1:0]       pulse,
    output logic [WIDTH-1:0]       flag,
    output logic [WIDTH*CNT_W-1:0] count,
    output logic                   any_pulse
);

    logic [WIDTH-1:0][CNT_W-1:0] w_count;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        edge_cell #(.CNT_W(CNT_W)) u_cell (
            .clk       (clk),
            .reset     (reset),
            .i_din     (din[g]),
            .i_inhibit (inhibit[g]),
            .i_mode    (mode),
            .i_clr     (clr),
            .o_pulse   (pulse[g]),
            .o_flag    (flag[g]),
            .o_count   (w_count[g])
        );
    end

    assign count     = w_count;
    assign any_pulse = |pulse;

endmodule

// File: tb/tb_inhibit_edge_bank.sv
// Randomized and directed stimulus for inhibit_edge_bank against a
// cycle-level reference model derived from the edge/flag/count rules.
module tb_inhibit_edge_bank;

    localparam int W = 4;
    localparam int C = 2;
    localparam int SAT = (1 << C) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   din;
    logic [W-1:0]   inhibit;
    logic [1:0]     mode;
    logic           clr;
    logic [W-1:0]   pulse;
    logic [W-1:0]   flag;
    logic [W*C-1:0] count;
    logic           any_pulse;

    int n_chk = 0;
    int n_err = 0;

    inhibit_edge_bank #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .inhibit   (inhibit),
        .mode      (mode),
        .clr       (clr),
        .pulse     (pulse),
        .flag      (flag),
        .count     (count),
        .any_pulse (any_pulse)
    );

    always #5 clk = ~clk;

    // Reference state: the last two din samples, pending pulses, flags, counts.
    bit m_cur [W];
    bit m_prv [W];
    bit m_pul [W];
    bit m_flg [W];
    int m_cnt [W];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int ch);
        cnt_of = int'((count >> (ch * C)) & SAT);
    endfunction

    // Advance one clock, update the model with the inputs present at the edge,
    // then compare every output just after the edge.
    task automatic step();
        logic [W-1:0]   ep, ef;
        logic [W*C-1:0] ec;
        bit             rise, fall, ev;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            if (reset) begin
                m_cur[i] = 0; m_prv[i] = 0; m_pul[i] = 0; m_flg[i] = 0; m_cnt[i] = 0;
            end else begin
                rise = m_cur[i] && !m_prv[i];
                fall = !m_cur[i] && m_prv[i];
                case (mode)
                    2'b00:   ev = rise;
                    2'b01:   ev = fall;
                    2'b10:   ev = rise || fall;
                    default: ev = 0;
                endcase
                if (clr) begin
                    m_flg[i] = 0;
                    m_cnt[i] = 0;
                end else if (m_pul[i]) begin
                    m_flg[i] = 1;
                    m_cnt[i] = (m_cnt[i] + 1 > SAT) ? SAT : m_cnt[i] + 1;
                end
                m_pul[i] = ev && !inhibit[i];
                m_prv[i] = m_cur[i];
                m_cur[i] = din[i];
            end
        end
        #1;
        ec = '0;
        for (int i = 0; i < W; i++) begin
            ep[i] = m_pul[i];
            ef[i] = m_flg[i];
            ec = ec | (W*C)'(m_cnt[i] << (i * C));
        end
        chk("pulse", 64'(pulse), 64'(ep));
        chk("flag", 64'(flag), 64'(ef));
        chk("count", 64'(count), 64'(ec));
        chk("any_pulse", 64'(any_pulse), 64'(|ep));
    endtask

    initial begin
        int npul;
        reset = 1; din = '0; inhibit = '0; mode = 2'b00; clr = 0;
        #2;
        // Reset then rise detect on channel 0
        step(); step();
        chk("rst_outs", 64'({pulse, flag, count, any_pulse}), 64'(0));
        reset = 0;
        step();
        din = 4'b0001;
        npul = 0;
        step();
        chk("rise_lat1", 64'(pulse), 64'(0));
        step();
        chk("rise_lat2", 64'(pulse), 64'(4'b0001));
        for (int k = 0; k < 3; k++) begin
            step();
            if (pulse != 0) npul++;
        end
        chk("rise_once", 64'(npul), 64'(0));
        chk("rise_flag", 64'(flag), 64'(4'b0001));
        chk("rise_cnt", 64'(count), 64'(1));

        // Both-edge glitch on channel 1
        mode = 2'b10; din = 4'b0011;
        step();
        din = 4'b0001;
        npul = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (any_pulse) npul++;
        end
        chk("glitch_ap", 64'(npul), 64'(2));
        chk("glitch_cnt1", 64'(cnt_of(1)), 64'(2));

        // Inhibited edge on channel 2 is dropped
        mode = 2'b00; inhibit = 4'b0100; din = 4'b0101;
        for (int k = 0; k < 4; k++) step();
        chk("inh_cnt2", 64'(cnt_of(2)), 64'(0));
        chk("inh_flag2", 64'(flag[2]), 64'(0));
        inhibit = '0; din = 4'b0001;
        step(); step(); step();
        // clr collides with the visible pulse on channel 2
        din = 4'b0101;
        step(); step();
        chk("coll_pulse", 64'(pulse[2]), 64'(1));
        clr = 1;
        step();
        clr = 0;
        chk("coll_flag2", 64'(flag[2]), 64'(0));
        chk("coll_cnt2", 64'(cnt_of(2)), 64'(0));

        // Saturation on channel 3
        for (int r = 1; r <= 5; r++) begin
            din[3] = 1'b1;
            step(); step(); step();
            chk("sat_cnt3", 64'(cnt_of(3)), 64'((r > SAT) ? SAT : r));
            din[3] = 1'b0;
            step(); step();
        end

        // Reset the cycle after a din[0] edge
        din = '0;
        for (int k = 0; k < 3; k++) step();
        din[0] = 1'b1;
        step();
        reset = 1; din = '0;
        step();
        reset = 0;
        npul = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (pulse != 0) npul++;
        end
        chk("rstmid_npul", 64'(npul), 64'(0));
        chk("rstmid_outs", 64'({flag, count}), 64'(0));

        // Reset release with din held high produces one rising pulse
        din = 4'b1111; reset = 1;
        step(); step();
        reset = 0;
        step();
        step();
        chk("rel_pulse", 64'(pulse), 64'(4'b1111));

        // Off mode
        mode = 2'b11;
        for (int k = 0; k < 10; k++) begin
            din = W'($urandom);
            step();
            chk("off_pulse", 64'(pulse), 64'(0));
        end

        // Randomized run against the model
        for (int k = 0; k < 600; k++) begin
            din     = W'($urandom);
            inhibit = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            clr     = ($urandom_range(0, 24) == 0);
            reset   = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
